rv32i_fetch: RTL and testbench

Instruction-fetch stage of the RV32I pipeline. Keeps the program counter and issues word requests to instruction memory over a single-outstanding request/acknowledge bus. Presents each returned 32-bit instruction with its PC to the decode stage through a valid/stall handshake backed by a one-entry skid buffer. Taken branches and jumps from execute redirect it through a registered PC-change input.

---
 rtl/rv32i_fetch_if.sv | 26 ++
 rtl/rv32i_fetch.sv | 138 +++++++++++++
 tb/tb_rv32i_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack plus the decode-side
// valid/stall handshake and the execute redirect.
interface rv32i_fetch_if;
  logic [31:0] iaddr;
  logic        istb;
  logic        iack;
  logic [31:0] idata;
  logic        stall;
  logic        change_pc;
  logic [31:0] new_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;

  // Fetch stage side.
  modport master (
    output iaddr, istb, inst, pc, valid,
    input  iack, idata, stall, change_pc, new_pc
  );

  // Memory / decode / execute side.
  modport slave (
    input  iaddr, istb, inst, pc, valid,
    output iack, idata, stall, change_pc, new_pc
  );
endinterface

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: PC register, single-outstanding imem requests,
// registered decode outputs backed by a one-entry skid buffer, and redirect.
module rv32i_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  rv32i_fetch_if.master bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_full_q, skid_full_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] tgt;
  logic        consume;

  assign tgt     = bus.new_pc & 32'hFFFF_FFFC;
  assign consume = valid_q & ~bus.stall;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      iaddr_q     <= PC_RESET;
      inst_q      <= Nop;
      pc_q        <= PC_RESET;
      valid_q     <= 1'b0;
      skid_inst_q <= Nop;
      skid_pc_q   <= PC_RESET;
      skid_full_q <= 1'b0;
      tgt_q       <= PC_RESET;
    end else begin
      state_q     <= state_d;
      iaddr_q     <= iaddr_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_full_q <= skid_full_d;
      tgt_q       <= tgt_d;
    end
  end

  // Next-state: redirect first, then per-state fetch / skid / drain handling.
  always_comb begin
    state_d     = state_q;
    iaddr_d     = iaddr_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_full_d = skid_full_q;
    tgt_d       = tgt_q;

    if (bus.change_pc) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
      unique case (state_q)
        StFetch, StDrain: begin
          if (bus.iack) begin
            // Response in flight lands now; drop it and go straight to target.
            iaddr_d = tgt;
            state_d = StFetch;
          end else begin
            // Can't move iaddr mid-request; remember where to go afterwards.
            tgt_d   = tgt;
            state_d = StDrain;
          end
        end
        default: begin
          iaddr_d = tgt;
          state_d = StFetch;
        end
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (bus.iack) begin
            iaddr_d = iaddr_q + 32'd4;
            if (!valid_q || consume) begin
              inst_d  = bus.idata;
              pc_d    = iaddr_q;
              valid_d = 1'b1;
            end else begin
              // Decode stalled: park the word and stop requesting.
              skid_inst_d = bus.idata;
              skid_pc_d   = iaddr_q;
              skid_full_d = 1'b1;
              state_d     = StWait;
            end
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        StWait: begin
          if (consume) begin
            inst_d      = skid_inst_q;
            pc_d        = skid_pc_q;
            skid_full_d = 1'b0;
            state_d     = StFetch;
          end
        end
        StDrain: begin
          if (bus.iack) begin
            iaddr_d = tgt_q;
            state_d = StFetch;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign bus.iaddr = iaddr_q;
  assign bus.istb  = (state_q == StFetch) || (state_q == StDrain);
  assign bus.inst  = inst_q;
  assign bus.pc    = pc_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch: a scoreboard of expected consumed (pc, inst)
// pairs is checked at every consume point, plus direct checks on each step.
module tb_rv32i_fetch;

  logic clk;
  logic rst_n;

  rv32i_fetch_if bus ();
  rv32i_fetch_if bus2 ();

  rv32i_fetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  rv32i_fetch #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.master)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t sb_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.idata       = mem(bus.iaddr);
  assign bus2.idata      = mem(bus2.iaddr);
  assign bus2.iack       = 1'b1;
  assign bus2.stall      = 1'b0;
  assign bus2.change_pc  = 1'b0;
  assign bus2.new_pc     = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    item_t it;
    it.pc   = a;
    it.inst = mem(a);
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed output must match the next expected item.
  always @(negedge clk) begin
    if (rst_n && bus.valid === 1'b1 && bus.stall === 1'b0) begin
      checks++;
      if (sb_q.size() == 0) begin
        assert (0) else begin
          failures++;
          $error("FAIL sb_unexpected: observed pc=%h inst=%h expected none", bus.pc, bus.inst);
        end
      end else begin
        item_t e;
        e = sb_q.pop_front();
        assert (bus.pc === e.pc && bus.inst === e.inst) else begin
          failures++;
          $error("FAIL sb_item: observed pc=%h inst=%h expected pc=%h inst=%h",
                 bus.pc, bus.inst, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.iack      = 1'b0;
    bus.stall     = 1'b0;
    bus.change_pc = 1'b0;
    bus.new_pc    = 32'h0;
    #22;
    chk("rst_istb", {31'b0, bus.istb}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'h0000_0013);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_wrap_iaddr", bus2.iaddr, 32'hFFFF_FFF8);

    bus.iack = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Startup: idle -> fetch, then one instruction per cycle.
    step();
    chk("start_istb", {31'b0, bus.istb}, 32'd1);
    chk("start_valid", {31'b0, bus.valid}, 32'd0);
    chk("start_iaddr", bus.iaddr, 32'h0);
    push(32'h0);
    step();
    chk("first_valid", {31'b0, bus.valid}, 32'd1);
    chk("first_pc", bus.pc, 32'h0);
    chk("wrap_pc0", bus2.pc, 32'hFFFF_FFF8);
    push(32'h4);
    step();
    chk("wrap_pc1", bus2.pc, 32'hFFFF_FFFC);
    push(32'h8);
    step();
    chk("wrap_pc2", bus2.pc, 32'h0000_0000);
    push(32'hC);
    step();
    chk("stream_pc12", bus.pc, 32'hC);

    // Redirect into the 0x100 stream, then stall with skid.
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h100;
    step();
    bus.change_pc = 1'b0;
    chk("redir100_valid", {31'b0, bus.valid}, 32'd0);
    chk("redir100_iaddr", bus.iaddr, 32'h100);
    push(32'h100);
    step();
    push(32'h104);
    step();
    chk("pre_stall_pc", bus.pc, 32'h104);
    bus.stall = 1'b1;
    push(32'h108);
    push(32'h10C);
    step();
    chk("stall1_pc", bus.pc, 32'h104);
    chk("stall1_istb", {31'b0, bus.istb}, 32'd0);
    step();
    chk("stall2_pc", bus.pc, 32'h104);
    chk("stall2_iaddr", bus.iaddr, 32'h10C);
    step();
    chk("stall3_valid", {31'b0, bus.valid}, 32'd1);
    bus.stall = 1'b0;
    step();
    chk("skid_out_pc", bus.pc, 32'h108);
    chk("skid_out_istb", {31'b0, bus.istb}, 32'd1);
    step();
    chk("after_skid_pc", bus.pc, 32'h10C);

    // Redirect with a same-cycle ack at 0x40.
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h40;
    step();
    bus.new_pc = 32'h2003;
    step();
    bus.change_pc = 1'b0;
    chk("ack_redir_valid", {31'b0, bus.valid}, 32'd0);
    chk("ack_redir_iaddr", bus.iaddr, 32'h2000);
    push(32'h2000);
    step();
    chk("ack_redir_pc", bus.pc, 32'h2000);

    // Redirect while a request to 0x80 is outstanding.
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h80;
    step();
    bus.change_pc = 1'b0;
    bus.iack      = 1'b0;
    step();
    chk("wait80_iaddr", bus.iaddr, 32'h80);
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h300;
    step();
    bus.change_pc = 1'b0;
    chk("drain_iaddr", bus.iaddr, 32'h80);
    chk("drain_istb", {31'b0, bus.istb}, 32'd1);
    step();
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h400;
    step();
    bus.change_pc = 1'b0;
    chk("drain2_iaddr", bus.iaddr, 32'h80);
    bus.iack = 1'b1;
    step();
    chk("drain_done_iaddr", bus.iaddr, 32'h400);
    chk("drain_done_valid", {31'b0, bus.valid}, 32'd0);
    step();
    chk("drain_first_pc", bus.pc, 32'h400);

    // Redirect overrides a full skid under stall.
    bus.stall = 1'b1;
    step();
    chk("skidfull_istb", {31'b0, bus.istb}, 32'd0);
    bus.change_pc = 1'b1;
    bus.new_pc    = 32'h500;
    step();
    bus.change_pc = 1'b0;
    chk("ovr_valid", {31'b0, bus.valid}, 32'd0);
    chk("ovr_istb", {31'b0, bus.istb}, 32'd1);
    chk("ovr_iaddr", bus.iaddr, 32'h500);
    bus.stall = 1'b0;
    push(32'h500);
    step();
    push(32'h504);
    step();
    chk("ovr_next_pc", bus.pc, 32'h504);
    bus.iack = 1'b0;
    step();
    chk("idle_stream_valid", {31'b0, bus.valid}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a hung run still ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
